// File: rtl/axis2lbus_tx_seg_pkg.sv
// -----------------------------------------------------------------------------
// lbus_pkg: shared definitions for the AXI4-Stream to LBUS transmit converter.
//   SEG_BYTES_DEF : default bytes per LBUS segment
//   pkt_state_e   : packet FSM encoding (IDLE / INPKT)
//   mty_of()      : empty-byte count of a segment keep vector (popcount based)
//   keep_contig() : keep vector is a run of ones starting at bit 0 (or empty)
// Keep vectors are passed zero-extended to 64 bits, the largest segment size.
// -----------------------------------------------------------------------------
package lbus_pkg;

  localparam int SEG_BYTES_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    INPKT = 1'b1
  } pkt_state_e;

  function automatic logic [6:0] mty_of(input logic [63:0] keep, input int seg_bytes);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int b = 0; b < 64; b++) begin
      cnt = cnt + {6'd0, keep[b]};
    end
    return 7'(seg_bytes) - cnt;
  endfunction

  // A contiguous-from-0 mask plus one has no bit in common with the mask.
  function automatic logic keep_contig(input logic [63:0] keep);
    return ((keep & (keep + 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/axis2lbus_tx_seg_if.sv
// -----------------------------------------------------------------------------
// axis2lbus_tx_seg_if: AXIS slave side plus segmented LBUS master side of the
// converter. Modport slave is the converter's view, master the driver's view.
//   s_axis_tdata/tkeep/tlast/tvalid -> converter, s_axis_tready <- converter
//   lbus_data/ena/sop/eop/mty/err   <- converter, lbus_rdy -> converter
//   keep_err                        <- converter (sticky malformed-tkeep flag)
// -----------------------------------------------------------------------------
interface axis2lbus_tx_seg_if
  import lbus_pkg::*;
#(
  parameter int NUM_SEG   = 4,
  parameter int SEG_BYTES = SEG_BYTES_DEF
);
  localparam int MTY_W = $clog2(SEG_BYTES);
  localparam int DW    = NUM_SEG * SEG_BYTES * 8;

  logic [DW-1:0]            s_axis_tdata;
  logic [NUM_SEG*SEG_BYTES-1:0] s_axis_tkeep;
  logic                     s_axis_tlast;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [DW-1:0]            lbus_data;
  logic [NUM_SEG-1:0]       lbus_ena;
  logic [NUM_SEG-1:0]       lbus_sop;
  logic [NUM_SEG-1:0]       lbus_eop;
  logic [NUM_SEG*MTY_W-1:0] lbus_mty;
  logic [NUM_SEG-1:0]       lbus_err;
  logic                     lbus_rdy;
  logic                     keep_err;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, lbus_rdy,
    output s_axis_tready, lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_mty,
           lbus_err, keep_err
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, lbus_rdy,
    input  s_axis_tready, lbus_data, lbus_ena, lbus_sop, lbus_eop, lbus_mty,
           lbus_err, keep_err
  );

endinterface

// File: rtl/axis2lbus_tx_seg_conv.sv
// -----------------------------------------------------------------------------
// lbus_seg_conv: combinational conversion of one SEG_BYTES segment.
//   data_i/keep_i : AXIS segment slice (byte 0 in bits [7:0])
//   data_o        : byte-reversed segment (LBUS is MSB-first)
//   ena_o         : any byte kept
//   mty_o         : SEG_BYTES - popcount(keep_i), truncated to MTY_W
//   contig_o      : keep_i is contiguous from bit 0
//   full_o        : every byte kept
// -----------------------------------------------------------------------------
module lbus_seg_conv
  import lbus_pkg::*;
#(
  parameter  int SEG_BYTES = SEG_BYTES_DEF,
  localparam int MTY_W     = $clog2(SEG_BYTES)
) (
  input  logic [SEG_BYTES*8-1:0] data_i,
  input  logic [SEG_BYTES-1:0]   keep_i,
  output logic [SEG_BYTES*8-1:0] data_o,
  output logic                   ena_o,
  output logic [MTY_W-1:0]       mty_o,
  output logic                   contig_o,
  output logic                   full_o
);

  logic [63:0] keep_ext;

  assign keep_ext = 64'(keep_i);
  assign ena_o    = |keep_i;
  assign full_o   = &keep_i;
  assign contig_o = keep_contig(keep_ext);
  assign mty_o    = MTY_W'(mty_of(keep_ext, SEG_BYTES));

  // Byte reversal within the segment
  always_comb begin
    data_o = {(SEG_BYTES*8){1'b0}};
    for (int j = 0; j < SEG_BYTES; j++) begin
      data_o[j*8 +: 8] = data_i[(SEG_BYTES-1-j)*8 +: 8];
    end
  end

endmodule

// File: rtl/axis2lbus_tx_seg.sv
// -----------------------------------------------------------------------------
// axis2lbus_tx_seg: registered multi-segment AXI4-Stream to LBUS TX converter.
// Each accepted AXIS beat is split into NUM_SEG segments of SEG_BYTES bytes,
// annotated with ena/sop/eop/mty/err, and pushed through an output register
// backed by one skid register so lbus_rdy backpressure costs no throughput.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : axis2lbus_tx_seg_if.slave (AXIS in, LBUS out, keep_err)
// Optional build macro AXIS2LBUS_KEEP_CHECK_EN enables malformed-tkeep
// detection (lbus_err on the eop segment, sticky keep_err). Without it both
// stay 0 and beats with tkeep=0 never reach the output.
// -----------------------------------------------------------------------------
module axis2lbus_tx_seg
  import lbus_pkg::*;
#(
  parameter  int NUM_SEG   = 4,
  parameter  int SEG_BYTES = SEG_BYTES_DEF,
  localparam int MTY_W     = $clog2(SEG_BYTES)
) (
  input logic               clk,
  input logic               rst,
  axis2lbus_tx_seg_if.slave bus
);

  localparam int DW = NUM_SEG * SEG_BYTES * 8;
  localparam int MW = NUM_SEG * MTY_W;

`ifdef AXIS2LBUS_KEEP_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0]      data;
    logic [NUM_SEG-1:0] ena;
    logic [NUM_SEG-1:0] sop;
    logic [NUM_SEG-1:0] eop;
    logic [MW-1:0]      mty;
    logic [NUM_SEG-1:0] err;
  } beat_t;

  logic [DW-1:0]      cv_data;
  logic [NUM_SEG-1:0] cv_ena, cv_contig, cv_full;
  logic [MW-1:0]      cv_mty;

  beat_t      nb, out_q, out_d, skid_q, skid_d;
  logic       skid_full_q, skid_full_d, tready_q, tready_d, keep_err_q, keep_err_d;
  logic       keep_zero, seg_gap, malformed, drop, accept, keep_beat, advance;
  int         hi_idx;
  pkt_state_e state_q;

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    lbus_seg_conv #(.SEG_BYTES(SEG_BYTES)) u_conv (
      .data_i   (bus.s_axis_tdata[g*SEG_BYTES*8 +: SEG_BYTES*8]),
      .keep_i   (bus.s_axis_tkeep[g*SEG_BYTES +: SEG_BYTES]),
      .data_o   (cv_data[g*SEG_BYTES*8 +: SEG_BYTES*8]),
      .ena_o    (cv_ena[g]),
      .mty_o    (cv_mty[g*MTY_W +: MTY_W]),
      .contig_o (cv_contig[g]),
      .full_o   (cv_full[g])
    );
  end

  // Build the converted beat and classify the incoming tkeep
  always_comb begin
    keep_zero = (cv_ena == {NUM_SEG{1'b0}});
    hi_idx    = 0;
    seg_gap   = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (cv_ena[i]) hi_idx = i;
      else           hi_idx = hi_idx;
    end
    // A used segment above a partial one means keep is not contiguous overall.
    for (int i = 1; i < NUM_SEG; i++) begin
      if (cv_ena[i] && !cv_full[i-1]) seg_gap = 1'b1;
      else                            seg_gap = seg_gap;
    end
    if (CHECK_EN) begin
      malformed = (!bus.s_axis_tlast && !(&cv_full)) || !(&cv_contig) || seg_gap ||
                  (keep_zero && bus.s_axis_tlast);
    end else begin
      malformed = 1'b0;
    end
    drop      = keep_zero && !(bus.s_axis_tlast && CHECK_EN);
    accept    = bus.s_axis_tvalid && tready_q;
    keep_beat = accept && !drop;

    nb      = '0;
    nb.data = cv_data;
    if (keep_zero) begin
      // Bare tlast marker: close the packet on segment 0, flagged as an error.
      nb.ena[0] = 1'b1;
      nb.sop[0] = (state_q == IDLE);
      nb.eop[0] = 1'b1;
      nb.err[0] = CHECK_EN;
    end else begin
      nb.ena = cv_ena;
      // Lowest set bit of ena marks the start segment.
      if (state_q == IDLE) nb.sop = cv_ena & (~cv_ena + NUM_SEG'(1'b1));
      else                 nb.sop = {NUM_SEG{1'b0}};
      if (bus.s_axis_tlast) begin
        nb.eop[hi_idx]                 = 1'b1;
        nb.mty[hi_idx*MTY_W +: MTY_W]  = cv_mty[hi_idx*MTY_W +: MTY_W];
        nb.err[hi_idx]                 = malformed;
      end else begin
        nb.eop = {NUM_SEG{1'b0}};
      end
    end
  end

  // Output/skid next state; a full skid always drains first to keep order
  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    keep_err_d  = keep_err_q | (accept & malformed);
    advance     = bus.lbus_rdy | ~(|out_q.ena);
    if (advance) begin
      skid_full_d = 1'b0;
      if (skid_full_q) begin
        out_d = skid_q;
      end else if (keep_beat) begin
        out_d = nb;
      end else begin
        out_d      = '0;
        out_d.data = out_q.data;
      end
    end else if (keep_beat) begin
      skid_d      = nb;
      skid_full_d = 1'b1;
    end else begin
      skid_d = skid_q;
    end
    tready_d = ~skid_full_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      tready_q    <= 1'b0;
      keep_err_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      tready_q    <= tready_d;
      keep_err_q  <= keep_err_d;
    end
  end

  // Packet FSM: empty non-last beats leave the state untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (accept && !(keep_zero && !bus.s_axis_tlast)) begin
      state_q <= bus.s_axis_tlast ? IDLE : INPKT;
    end else begin
      state_q <= state_q;
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.lbus_data     = out_q.data;
  assign bus.lbus_ena      = out_q.ena;
  assign bus.lbus_sop      = out_q.sop;
  assign bus.lbus_eop      = out_q.eop;
  assign bus.lbus_mty      = out_q.mty;
  assign bus.lbus_err      = out_q.err;
  assign bus.keep_err      = keep_err_q;

endmodule

// File: tb/tb_axis2lbus_tx_seg.sv
// -----------------------------------------------------------------------------
// tb_axis2lbus_tx_seg: directed scoreboard bench for axis2lbus_tx_seg.
// Stimulus pushes hand-computed expected LBUS beats into a queue; a negedge
// monitor pops and compares every beat the MAC side accepts. A second
// instance with NUM_SEG=1 covers the single-segment configuration.
// Honours AXIS2LBUS_KEEP_CHECK_EN for the malformed-tkeep expectations.
// -----------------------------------------------------------------------------
module tb_axis2lbus_tx_seg;

  localparam int NS = 4;
  localparam int SB = 16;
  localparam int MW = 4;
  localparam int DW = NS * SB * 8;
  localparam int KW = NS * SB;
  localparam int HW = DW + 4 * NS + NS * MW;

`ifdef AXIS2LBUS_KEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0]    data;
    logic [NS-1:0]    ena, sop, eop, err;
    logic [NS*MW-1:0] mty;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis2lbus_tx_seg_if #(.NUM_SEG(NS), .SEG_BYTES(SB)) bus ();
  axis2lbus_tx_seg_if #(.NUM_SEG(1), .SEG_BYTES(SB))  bus1 ();

  axis2lbus_tx_seg #(.NUM_SEG(NS), .SEG_BYTES(SB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  axis2lbus_tx_seg #(.NUM_SEG(1), .SEG_BYTES(SB))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  exp_t       q[$];
  int         pop_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         bp_on = 1'b0;
  int         bp_idx = 0;
  logic [0:11] rdy_pat = 12'b1001_0110_0011;
  bit         run_chk = 1'b0;
  bit         hold_v = 1'b0;
  logic [HW-1:0] hold_snap;
  exp_t       me;

  function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < SB; j++)
        r[(s*SB+j)*8 +: 8] = d[(s*SB+SB-1-j)*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input int seed);
    logic [DW-1:0] r;
    for (int b = 0; b < DW/8; b++) r[b*8 +: 8] = 8'(seed * 37 + b * 3 + 1);
    return r;
  endfunction

  // lbus_rdy driver: always ready unless the backpressure pattern is active
  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      bus.lbus_rdy = rdy_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 12;
    end else begin
      bus.lbus_rdy = 1'b1;
    end
  end

  // Monitor: scoreboard pops, hold stability, tready only low with output held
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if ({bus.lbus_data, bus.lbus_ena, bus.lbus_sop, bus.lbus_eop, bus.lbus_err, bus.lbus_mty} !== hold_snap) begin
          errors++;
          $display("FAIL hold_stable cyc=%0d ena act=%b sop=%b eop=%b, output changed while lbus_rdy=0", cyc, bus.lbus_ena, bus.lbus_sop, bus.lbus_eop);
        end
      end
      if (run_chk && !bus.s_axis_tready) begin
        checks++;
        if (bus.lbus_ena == '0) begin
          errors++;
          $display("FAIL tready_low cyc=%0d tready=0 with empty output, required skid full", cyc);
        end
      end
      if (bus.lbus_ena != '0 && bus.lbus_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cyc=%0d ena=%b sop=%b eop=%b", cyc, bus.lbus_ena, bus.lbus_sop, bus.lbus_eop);
        end else begin
          me = q.pop_front();
          pop_cyc.push_back(cyc);
          if (bus.lbus_data !== me.data || bus.lbus_ena !== me.ena || bus.lbus_sop !== me.sop ||
              bus.lbus_eop !== me.eop || bus.lbus_mty !== me.mty || bus.lbus_err !== me.err) begin
            errors++;
            $display("FAIL beat cyc=%0d act ena=%b sop=%b eop=%b mty=%h err=%b req ena=%b sop=%b eop=%b mty=%h err=%b data act=%h req=%h",
                     cyc, bus.lbus_ena, bus.lbus_sop, bus.lbus_eop, bus.lbus_mty, bus.lbus_err,
                     me.ena, me.sop, me.eop, me.mty, me.err, bus.lbus_data, me.data);
          end
        end
      end
      hold_v    = (bus.lbus_ena != '0) && !bus.lbus_rdy;
      hold_snap = {bus.lbus_data, bus.lbus_ena, bus.lbus_sop, bus.lbus_eop, bus.lbus_err, bus.lbus_mty};
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit push,
                      input logic [NS-1:0] ena, input logic [NS-1:0] sop, input logic [NS-1:0] eop,
                      input logic [NS*MW-1:0] mty, input logic [NS-1:0] err);
    exp_t e;
    int   n;
    e.data = swap(d); e.ena = ena; e.sop = sop; e.eop = eop; e.mty = mty; e.err = err;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    if (push) q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s remaining=%0d required=0", tag, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", tag, act, req);
    end
  endtask

  localparam logic [KW-1:0] FULL = {KW{1'b1}};

  initial begin
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = 1'b0;
    bus1.s_axis_tvalid = 1'b0; bus1.s_axis_tdata = '0; bus1.s_axis_tkeep = '0; bus1.s_axis_tlast = 1'b0;
    bus1.lbus_rdy = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 128'({bus.lbus_ena, bus.lbus_sop, bus.lbus_eop, bus.lbus_mty, bus.lbus_err, bus.keep_err, bus.s_axis_tready}), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("tready_after_reset", 128'(bus.s_axis_tready), 128'd1);
    run_chk = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet spanning three segments
    send(mk(1), 64'h0000_0FFF_FFFF_FFFF, 1'b1, 1'b1, 4'b0111, 4'b0001, 4'b0100, 16'h0400, 4'b0000);
    drain("single");

    // Three back-to-back beats, last one two segments
    pop_cyc.delete();
    send(mk(2), FULL, 1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 4'b0000);
    send(mk(3), FULL, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    send(mk(4), 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010, 16'h0000, 4'b0000);
    drain("three");
    chk("three_count", 128'(pop_cyc.size()), 128'd3);
    if (pop_cyc.size() == 3) begin
      chk("rate_gap1", 128'(pop_cyc[1] - pop_cyc[0]), 128'd1);
      chk("rate_gap2", 128'(pop_cyc[2] - pop_cyc[1]), 128'd1);
    end

    // Eight beats under toggling lbus_rdy
    bp_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(mk(10 + k), FULL, (k == 7), 1'b1, 4'b1111, (k == 0) ? 4'b0001 : 4'b0000,
           (k == 7) ? 4'b1000 : 4'b0000, 16'h0000, 4'b0000);
    end
    drain("backpressure");
    bp_on = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Empty beats: non-last dropped silently, last one closes the packet
    send(mk(20), FULL, 1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 4'b0000);
    send(mk(21), '0,   1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    send(mk(22), '0,   1'b1, CHK,  4'b0001, 4'b0000, 4'b0001, 16'h0000, 4'b0001);
    send(mk(23), FULL, 1'b1, 1'b1, 4'b1111, 4'b0001, 4'b1000, 16'h0000, 4'b0000);
    drain("empty_beats");

    // Reset in the middle of a packet
    send(mk(30), FULL, 1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 4'b0000);
    send(mk(31), FULL, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 4'b0000);
    drain("pre_reset");
    run_chk = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 128'({bus.lbus_ena, bus.lbus_sop, bus.lbus_eop, bus.lbus_mty, bus.lbus_err, bus.keep_err, bus.s_axis_tready}), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_chk = 1'b1;
    send(mk(32), FULL, 1'b1, 1'b1, 4'b1111, 4'b0001, 4'b1000, 16'h0000, 4'b0000);
    drain("post_reset");

`ifdef AXIS2LBUS_KEEP_CHECK_EN
    chk("keep_err_cleared", 128'(bus.keep_err), 128'd0);
    send(mk(40), 64'hFFFF_FFFF_FFFF_FFDF, 1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 4'b0000);
    @(negedge clk);
    chk("keep_err_set", 128'(bus.keep_err), 128'd1);
    @(posedge clk); #1;
    send(mk(41), 64'h0000_0000_0000_00F0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 16'h000C, 4'b0001);
    drain("malformed");
    chk("keep_err_sticky", 128'(bus.keep_err), 128'd1);
`else
    chk("keep_err_idle", 128'(bus.keep_err), 128'd0);
`endif

    // Single-segment instance
    bus1.s_axis_tdata  = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FFA5;
    bus1.s_axis_tkeep  = 16'h0001;
    bus1.s_axis_tlast  = 1'b1;
    bus1.s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("seg1_tready", 128'(bus1.s_axis_tready), 128'd1);
    @(posedge clk); #1;
    bus1.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("seg1_flags", 128'({bus1.lbus_ena, bus1.lbus_sop, bus1.lbus_eop, bus1.lbus_mty, bus1.lbus_err}),
        128'({1'b1, 1'b1, 1'b1, 4'd15, 1'b0}));
    chk("seg1_data", bus1.lbus_data, 128'hA5FF_EEDD_CCBB_AA99_8877_6655_4433_2211);

    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
